control_unit: RTL
=================

# control_unit

Moore-style sequencer that drives every control input of `datapath` for the Mini-SRC CPU. It replaces hand-timed testbench stimulus. It walks a three-state instruction fetch, decodes `IR[31:27]`, and steps through one execute state per clock. It covers load/store, immediate load, register ALU ops, conditional branch, nop and halt. It sits beside `datapath`, taking `IR` and `CON_Out` back from it.

## Interface
- `RESET_STATE_RUN`, default 1: value of `Run` after reset.
- `Clock` in 1: single system clock; all state changes on its rising edge.
- `Clear` in 1: asynchronous, active-high reset; also passed through to `datapath`.
- `IR` in 32: instruction register contents from `datapath`.
- `CON_FF` in 1: `CON_Out` from `datapath`.
- `Stop` in 1: level request to halt at the next instruction boundary.
- `Run` out 1: high while executing; low in HALT.
- Register-enable outputs, 1 bit each: `PCin`, `IRin`, `HIin`, `LOin`, `ZHighin`, `ZLowin`, `MARin`, `MDRin`, `OutPort`, `Yin`.
- Bus-source outputs, 1 bit each: `PCout`, `HIout`, `LOout`, `ZHighout`, `ZLowout`, `InPort`, `MDRout`, `Cout`.
- Register-file and memory outputs, 1 bit each: `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`, `Read`, `Write`, `IncPC`, `GLR`, `CON_In`.
- `OP` out 5: ALU operation select.

## Operation
- State register holds one state; all outputs are a pure decode of the current state (Moore).
  - Outputs not listed for a state are 0.
  - `OP` is 5'b00000 unless listed.
  - `GLR`, `HIin`, `LOin`, `HIout`, `LOout`, `ZHighout`, `InPort` and `OutPort` are tied 0 in this revision.
- Reset: `Clear`=1 forces state RESET immediately, all control outputs 0, `Run`=`RESET_STATE_RUN`.
  - RESET moves to F0 on the first rising edge after `Clear` deasserts.
  - `Clear` mid-instruction aborts it with no further outputs.
- Fetch states:
  - F0: `PCout MARin IncPC`.
  - F1: `Read MDRin`.
  - F2: `MDRout IRin`. The next state is decoded from `IR[31:27]` as loaded at this edge; decode happens in the state after F2, using the registered IR.
- D (decode, no outputs) selects the first execute state from the opcode:
  - ld 00000
  - ldi 00001
  - st 00010
  - ALU 00100–01011 (add, sub, and, or, shr, shl, ror, rol)
  - br 10010
  - nop 11010
  - halt 11011
  - Any other opcode is treated as nop.
- Execute states:
  - ld:
    - E3: `Grb BAout Yin`
    - E4: `Cout OP=00100 ZHighin ZLowin`
    - E5: `ZLowout MARin`
    - E6: `Read MDRin`
    - E7: `MDRout Gra Rin`
  - ldi: E3, E4 as ld; then E5: `ZLowout Gra Rin`.
  - st: E3–E5 as ld; then E6: `Gra Rout MDRin` (`Read`=0, so MDR takes the bus); then E7: `Write`.
  - ALU:
    - E3: `Grb Rout Yin`
    - E4: `Grc Rout OP=IR[31:27] ZHighin ZLowin`
    - E5: `ZLowout Gra Rin`
  - br:
    - E3: `Gra Rout CON_In`
    - E4: `PCout Yin`
    - E5: `Cout OP=00100 ZLowin`
    - E6: `ZLowout`, plus `PCin` only if `CON_FF`=1 in this state.
  - nop: D goes directly to F0.
  - halt: D goes to HALT. HALT has all outputs 0 and `Run`=0, and holds until `Clear`.
- The last execute state of every instruction goes to F0, unless `Stop`=1 is sampled on that edge, in which case it goes to HALT.
- `Stop` is never sampled mid-instruction; the current instruction always completes.

## Timing
- One state per clock; outputs change only after a rising edge or on `Clear`.
- Cycles from F0 to the next F0, including D:
  - ldi 7
  - ALU 7
  - ld 9
  - st 9
  - br 8
  - nop 4
- `IR` must be stable from the F2 edge through the last execute state; `datapath` guarantees this because `IRin` is asserted only in F2.
- `CON_FF` is sampled combinationally during E6 of br; it must reflect the `CON_In` load from E3.
- `Read` and `Write` are never high together. `Rin` and `Rout` are never high in the same state.

## Test plan
- Reset: hold `Clear`=1 for 3 cycles mid-F1 → all outputs 0 immediately, `Run`=1. First edge after release gives F0 with `PCout`=`MARin`=`IncPC`=1.
- ldi: memory[0]=32'h08800075 (ldi R1,$75) → F0,F1,F2,D,E3(`Grb BAout Yin`),E4(`Cout`, `OP`=00100, `ZLowin`),E5(`ZLowout Gra Rin`). R1=32'h75, back in F0 after 7 cycles.
- ld/st round trip: `st` then `ld` of the same address → `Write` pulses exactly one cycle in st E7; the loaded register equals the stored value; `Read` is never high with `Write`.
- ALU: add R3,R1,R2 with R1=5, R2=7 → `OP`=5'b00100 only in E4; R3=12 after E5.
- Branch: br with CON true vs false, target PC+4+0x10 → `PCin` pulses in E6 only when `CON_FF`=1; PC is unchanged (beyond increment) when false.
- Stop/halt: raise `Stop` during ALU E4 → instruction completes, then HALT with `Run`=0. Opcode 11011 also gives HALT. Only `Clear` exits HALT.

Source files
------------

// File: rtl/control_unit.sv
// Moore sequencer for the Mini-SRC datapath: three-state fetch, one decode
// state, then one state per execute step for ld/ldi/st/ALU/br/nop/halt.
module control_unit #(
  parameter logic RESET_STATE_RUN = 1'b1
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Run,
  output logic        PCin,
  output logic        IRin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHighin,
  output logic        ZLowin,
  output logic        MARin,
  output logic        MDRin,
  output logic        OutPort,
  output logic        Yin,
  output logic        PCout,
  output logic        HIout,
  output logic        LOout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        InPort,
  output logic        MDRout,
  output logic        Cout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Read,
  output logic        Write,
  output logic        IncPC,
  output logic        GLR,
  output logic        CON_In,
  output logic [4:0]  OP
);

  localparam logic [4:0] S_RESET = 5'd0;
  localparam logic [4:0] S_F0    = 5'd1;
  localparam logic [4:0] S_F1    = 5'd2;
  localparam logic [4:0] S_F2    = 5'd3;
  localparam logic [4:0] S_D     = 5'd4;
  localparam logic [4:0] S_LD3   = 5'd5;
  localparam logic [4:0] S_LD4   = 5'd6;
  localparam logic [4:0] S_LD5   = 5'd7;
  localparam logic [4:0] S_LD6   = 5'd8;
  localparam logic [4:0] S_LD7   = 5'd9;
  localparam logic [4:0] S_LDI3  = 5'd10;
  localparam logic [4:0] S_LDI4  = 5'd11;
  localparam logic [4:0] S_LDI5  = 5'd12;
  localparam logic [4:0] S_ST3   = 5'd13;
  localparam logic [4:0] S_ST4   = 5'd14;
  localparam logic [4:0] S_ST5   = 5'd15;
  localparam logic [4:0] S_ST6   = 5'd16;
  localparam logic [4:0] S_ST7   = 5'd17;
  localparam logic [4:0] S_ALU3  = 5'd18;
  localparam logic [4:0] S_ALU4  = 5'd19;
  localparam logic [4:0] S_ALU5  = 5'd20;
  localparam logic [4:0] S_BR3   = 5'd21;
  localparam logic [4:0] S_BR4   = 5'd22;
  localparam logic [4:0] S_BR5   = 5'd23;
  localparam logic [4:0] S_BR6   = 5'd24;
  localparam logic [4:0] S_HALT  = 5'd25;

  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ROL  = 5'b01011;
  localparam logic [4:0] OPC_BR   = 5'b10010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  logic [4:0] state_q, state_d;
  logic [4:0] opc;
  logic       unused_ir_bits;

  assign opc            = IR[31:27];
  assign unused_ir_bits = ^IR[26:0];

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  // Last execute state of each instruction is the only place Stop is honoured.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_F0;
      S_F0:    state_d = S_F1;
      S_F1:    state_d = S_F2;
      S_F2:    state_d = S_D;
      S_D: begin
        if (opc == OPC_LD)                          state_d = S_LD3;
        else if (opc == OPC_LDI)                    state_d = S_LDI3;
        else if (opc == OPC_ST)                     state_d = S_ST3;
        else if (opc >= OPC_ADD && opc <= OPC_ROL)  state_d = S_ALU3;
        else if (opc == OPC_BR)                     state_d = S_BR3;
        else if (opc == OPC_HALT)                   state_d = S_HALT;
        else                                        state_d = S_F0;
      end
      S_LD3:   state_d = S_LD4;
      S_LD4:   state_d = S_LD5;
      S_LD5:   state_d = S_LD6;
      S_LD6:   state_d = S_LD7;
      S_LDI3:  state_d = S_LDI4;
      S_LDI4:  state_d = S_LDI5;
      S_ST3:   state_d = S_ST4;
      S_ST4:   state_d = S_ST5;
      S_ST5:   state_d = S_ST6;
      S_ST6:   state_d = S_ST7;
      S_ALU3:  state_d = S_ALU4;
      S_ALU4:  state_d = S_ALU5;
      S_BR3:   state_d = S_BR4;
      S_BR4:   state_d = S_BR5;
      S_BR5:   state_d = S_BR6;
      S_LD7, S_LDI5, S_ST7, S_ALU5, S_BR6:
               state_d = Stop ? S_HALT : S_F0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  assign GLR      = 1'b0;
  assign HIin     = 1'b0;
  assign LOin     = 1'b0;
  assign HIout    = 1'b0;
  assign LOout    = 1'b0;
  assign ZHighout = 1'b0;
  assign InPort   = 1'b0;
  assign OutPort  = 1'b0;

  always_comb begin
    if (state_q == S_HALT)       Run = 1'b0;
    else if (state_q == S_RESET) Run = RESET_STATE_RUN;
    else                         Run = 1'b1;
  end

  always_comb begin
    PCin = 1'b0; IRin = 1'b0; ZHighin = 1'b0; ZLowin = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0; PCout = 1'b0;
    ZLowout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Read = 1'b0; Write = 1'b0; IncPC = 1'b0; CON_In = 1'b0;
    OP = 5'b00000;
    case (state_q)
      S_F0:                  begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      S_F1, S_LD6:           begin Read = 1'b1; MDRin = 1'b1; end
      S_F2:                  begin MDRout = 1'b1; IRin = 1'b1; end
      S_LD3, S_LDI3, S_ST3:  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
      S_LD4, S_LDI4, S_ST4:  begin Cout = 1'b1; OP = OPC_ADD; ZHighin = 1'b1; ZLowin = 1'b1; end
      S_LD5, S_ST5:          begin ZLowout = 1'b1; MARin = 1'b1; end
      S_LD7:                 begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      S_LDI5, S_ALU5:        begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      S_ST6:                 begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
      S_ST7:                 Write = 1'b1;
      S_ALU3:                begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
      S_ALU4:                begin Grc = 1'b1; Rout = 1'b1; OP = opc; ZHighin = 1'b1; ZLowin = 1'b1; end
      S_BR3:                 begin Gra = 1'b1; Rout = 1'b1; CON_In = 1'b1; end
      S_BR4:                 begin PCout = 1'b1; Yin = 1'b1; end
      S_BR5:                 begin Cout = 1'b1; OP = OPC_ADD; ZLowin = 1'b1; end
      // Branch target is committed only when the condition flop says so.
      S_BR6:                 begin ZLowout = 1'b1; PCin = CON_FF; end
      default: ;
    endcase
  end

endmodule
